// File: rtl/motor_pwm.sv
// H-bridge PWM output stage: turns a signed PID command into registered pwm/dir/brake,
// with period-aligned duty updates, dead-time braking on reversal and a period strobe.
`ifndef PID_RES
`define PID_RES 16
`endif

module motor_pwm #(
    parameter int nbits    = `PID_RES,
    parameter int cnt_bits = 10,
    parameter int period   = 1000,
    parameter int duty_max = 950,
    parameter int dead     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbits-1:0] cmd_i,
    input  logic             cmd_valid_i,
    output logic             pwm_o,
    output logic             dir_o,
    output logic             brake_o,
    output logic             period_o
);
    localparam int DUTY_W = cnt_bits + 1;
    localparam int MAG_W  = nbits + 1;
    localparam int CMP_W  = (MAG_W > DUTY_W) ? MAG_W : DUTY_W;
    localparam int DEAD_W = (dead > 1) ? $clog2(dead) : 1;
    localparam logic [cnt_bits-1:0] CNT_LAST   = cnt_bits'(period - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(dead - 1);
    localparam logic [CMP_W-1:0]    DUTY_MAX_C = CMP_W'(duty_max);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t              state_r;
    logic [cnt_bits-1:0] cnt_r;
    logic [DEAD_W-1:0]   dead_cnt_r;
    logic [DUTY_W-1:0]   duty_r;
    logic                sh_sign_r;
    logic [DUTY_W-1:0]   sh_mag_r;
    logic                cmd_sign_s;
    logic [DUTY_W-1:0]   cmd_mag_s;
    logic                reverse_s;
    logic                sh_nonzero_s;
    logic [cnt_bits-1:0] cnt_inc_s;

    // |cmd| is formed one bit wider so the most negative code does not wrap before clamping
    function automatic logic [DUTY_W-1:0] sat_mag(input logic [nbits-1:0] cmd);
        logic [MAG_W-1:0] abs_v;
        logic [CMP_W-1:0] ext_v;
        if (cmd[nbits-1]) begin
            abs_v = {1'b0, ~cmd} + MAG_W'(1);
        end else begin
            abs_v = {1'b0, cmd};
        end
        ext_v = CMP_W'(abs_v);
        if (ext_v > DUTY_MAX_C) begin
            sat_mag = DUTY_W'(duty_max);
        end else begin
            sat_mag = DUTY_W'(ext_v);
        end
    endfunction

    // Decode the incoming command; a zero command inherits the present direction
    always_comb begin
        cmd_mag_s = sat_mag(cmd_i);
        if (cmd_i == {nbits{1'b0}}) begin
            cmd_sign_s = dir_o;
        end else begin
            cmd_sign_s = cmd_i[nbits-1];
        end
    end

    assign sh_nonzero_s = (sh_mag_r != {DUTY_W{1'b0}});
    assign reverse_s    = (sh_sign_r != dir_o) && sh_nonzero_s;
    assign cnt_inc_s    = cnt_r + cnt_bits'(1);

    // Shadow command register; the last strobe before a boundary wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_sign_r <= 1'b0;
            sh_mag_r  <= {DUTY_W{1'b0}};
        end else if (cmd_valid_i) begin
            sh_sign_r <= cmd_sign_s;
            sh_mag_r  <= cmd_mag_s;
        end else begin
            sh_sign_r <= sh_sign_r;
            sh_mag_r  <= sh_mag_r;
        end
    end

    // Main state machine with registered bridge outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {cnt_bits{1'b0}};
            dead_cnt_r <= {DEAD_W{1'b0}};
            duty_r     <= {DUTY_W{1'b0}};
            pwm_o      <= 1'b0;
            dir_o      <= 1'b0;
            brake_o    <= 1'b0;
            period_o   <= 1'b0;
        end else if (!en) begin
            state_r    <= IDLE;
            cnt_r      <= {cnt_bits{1'b0}};
            dead_cnt_r <= {DEAD_W{1'b0}};
            pwm_o      <= 1'b0;
            brake_o    <= 1'b0;
            period_o   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r  <= RUN;
                    duty_r   <= sh_mag_r;
                    dir_o    <= sh_sign_r;
                    cnt_r    <= {cnt_bits{1'b0}};
                    pwm_o    <= sh_nonzero_s;
                    brake_o  <= 1'b0;
                    period_o <= 1'b1;
                end
                RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        if (reverse_s) begin
                            state_r    <= DEAD;
                            dead_cnt_r <= {DEAD_W{1'b0}};
                            pwm_o      <= 1'b0;
                            brake_o    <= 1'b1;
                            period_o   <= 1'b0;
                        end else begin
                            duty_r   <= sh_mag_r;
                            cnt_r    <= {cnt_bits{1'b0}};
                            pwm_o    <= sh_nonzero_s;
                            period_o <= 1'b1;
                        end
                    end else begin
                        cnt_r    <= cnt_inc_s;
                        pwm_o    <= ({1'b0, cnt_inc_s} < duty_r);
                        period_o <= 1'b0;
                    end
                end
                DEAD: begin
                    if (dead_cnt_r == DEAD_LAST) begin
                        state_r  <= RUN;
                        dir_o    <= sh_sign_r;
                        duty_r   <= sh_mag_r;
                        cnt_r    <= {cnt_bits{1'b0}};
                        pwm_o    <= sh_nonzero_s;
                        brake_o  <= 1'b0;
                        period_o <= 1'b1;
                    end else begin
                        dead_cnt_r <= dead_cnt_r + DEAD_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    pwm_o    <= 1'b0;
                    brake_o  <= 1'b0;
                    period_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_motor_pwm.sv
// Self-checking bench for motor_pwm: directed scenarios plus random commands,
// compared cycle by cycle against a queue-of-segments reference model.
module tb_motor_pwm;
    localparam int PERIOD = 100;
    localparam int DMAX   = 90;
    localparam int DEAD   = 4;
    localparam int NB     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic [NB-1:0] cmd_i = '0;
    logic          pwm_o, dir_o, brake_o, period_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic pwm;
        logic dir;
        logic brake;
        logic per;
        int   pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic m_sign, m_dir, running, pending_dead;
    int   m_mag;

    motor_pwm #(
        .nbits(NB), .cnt_bits(10), .period(PERIOD), .duty_max(DMAX), .dead(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
        .pwm_o(pwm_o), .dir_o(dir_o), .brake_o(brake_o), .period_o(period_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, want);
        end
    endtask

    // One whole period of expected samples, taken from the shadow command
    task automatic start_period();
        exp_t e;
        m_dir = m_sign;
        for (int i = 0; i < PERIOD; i++) begin
            e.pwm = (i < m_mag); e.dir = m_dir; e.brake = 1'b0; e.per = (i == 0); e.pos = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_edge(input logic en_v, input logic vld, input int cmd);
        exp_t e;
        logic dir_before;
        dir_before = m_dir;
        if (!en_v) begin
            running = 1'b0; pending_dead = 1'b0; exp_q.delete();
            cur.pwm = 1'b0; cur.dir = m_dir; cur.brake = 1'b0; cur.per = 1'b0; cur.pos = -1;
        end else begin
            if (!running) begin
                running = 1'b1;
                start_period();
            end else if (exp_q.size() == 0) begin
                if (pending_dead) begin
                    pending_dead = 1'b0;
                    start_period();
                end else if (m_sign != m_dir && m_mag != 0) begin
                    pending_dead = 1'b1;
                    for (int i = 0; i < DEAD; i++) begin
                        e.pwm = 1'b0; e.dir = m_dir; e.brake = 1'b1; e.per = 1'b0; e.pos = -1;
                        exp_q.push_back(e);
                    end
                end else begin
                    start_period();
                end
            end
            cur = exp_q.pop_front();
        end
        if (vld) begin
            m_mag  = (cmd < 0) ? -cmd : cmd;
            if (m_mag > DMAX) m_mag = DMAX;
            m_sign = (cmd == 0) ? dir_before : (cmd < 0);
        end
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic cycle(input logic en_v, input logic vld, input int cmd);
        en = en_v; cmd_valid_i = vld; cmd_i = NB'(cmd);
        model_edge(en_v, vld, cmd);
        @(posedge clk); #1;
        chk("pwm", pwm_o, cur.pwm);
        chk("dir", dir_o, cur.dir);
        chk("brake", brake_o, cur.brake);
        chk("period", period_o, cur.per);
        chk("pwm_brake_excl", pwm_o & brake_o, 1'b0);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
    endtask

    task automatic go_to(input int p);
        int guard;
        guard = 0;
        while (cur.pos != p && guard < 400) begin
            cycle(1'b1, 1'b0, 0);
            guard++;
        end
        chk("goto_bound", cur.pos, p);
    endtask

    task automatic do_reset();
        rst = 1'b1; #1;
        chk("rst_pwm", pwm_o, 1'b0);
        chk("rst_dir", dir_o, 1'b0);
        chk("rst_brake", brake_o, 1'b0);
        chk("rst_period", period_o, 1'b0);
        running = 1'b0; pending_dead = 1'b0; exp_q.delete();
        m_sign = 1'b0; m_mag = 0; m_dir = 1'b0; cur.pos = -1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0; cmd_valid_i = 1'b0;
    endtask

    initial begin
        int sel, cmd;
        logic en_v, vld;
        @(negedge clk);
        do_reset();

        // basic duty
        cycle(1'b0, 1'b1, 40);
        run(250);
        // reversal mid-period
        go_to(10); cycle(1'b1, 1'b1, -25); run(300);
        // saturation both ways
        go_to(5); cycle(1'b1, 1'b1, 500); run(250);
        go_to(5); cycle(1'b1, 1'b1, -32768); run(250);
        // zero command, then late strobe
        go_to(5); cycle(1'b1, 1'b1, -25); run(200);
        go_to(5); cycle(1'b1, 1'b1, 0); run(150);
        go_to(99); cycle(1'b1, 1'b1, 30); run(320);
        // last strobe wins
        go_to(3); cycle(1'b1, 1'b1, 10);
        go_to(50); cycle(1'b1, 1'b1, 60); run(200);
        // asynchronous reset mid-period
        go_to(5); cycle(1'b1, 1'b1, 40); run(120);
        go_to(20);
        chk("pre_rst_pwm", pwm_o, 1'b1);
        do_reset();
        cycle(1'b0, 1'b1, 40);
        run(150);
        // enable drop and re-enable
        go_to(20);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        chk("reenable_strobe", period_o, 1'b1);
        run(150);

        // random phase
        for (int i = 0; i < 2000; i++) begin
            en_v = ($urandom_range(0, 199) != 0);
            vld  = ($urandom_range(0, 39) == 0);
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       cmd = -32768;
                1:       cmd = 32767;
                2:       cmd = 0;
                default: cmd = $urandom_range(0, 240) - 120;
            endcase
            cycle(en_v, vld, cmd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_pwm.md
# motor_pwm

Output stage of the motor control loop. Consumes the signed control output of the PID stage and turns it into a registered PWM/direction/brake triple for one H-bridge channel. Clamps the command magnitude and applies new duty only at period boundaries. Inserts a dead-time brake interval on every direction reversal. Emits a once-per-period strobe that the loop uses to trigger the next PID computation.

## Interface

- `nbits`, default `` `PID_RES ``: command width, two's complement.
- `cnt_bits`, default 10: width of the period and duty counters.
- `period`, default 1000: PWM period in clk cycles, 2..2^cnt_bits.
- `duty_max`, default 950: maximum high cycles per period, at most `period`.
- `dead`, default 20: brake cycles on reversal, at least 1.

Ports:

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: run enable. Low forces IDLE.
- `cmd_i`, in, nbits: signed command.
- `cmd_valid_i`, in, 1: one-cycle strobe; captures `cmd_i`.
- `pwm_o`, out, 1: bridge PWM.
- `dir_o`, out, 1: 0 = forward (cmd ≥ 0), 1 = reverse.
- `brake_o`, out, 1: high during dead-time.
- `period_o`, out, 1: one-cycle strobe at each period start.

## Operation

- **Shadow register.** On `cmd_valid_i`, store sign and saturated magnitude.
  - mag = min(|cmd_i|, duty_max).
  - |−2^(nbits−1)| = 2^(nbits−1), computed without overflow, then clamped.
  - The last strobe before a boundary wins.
- **Zero command.** cmd = 0 keeps the stored sign equal to the current `dir_o`, so no reversal occurs.
- **Active registers.** Active duty and `dir_o` change only at boundaries or at the end of DEAD.
- **IDLE**
  - `pwm_o`=0, `brake_o`=0, `dir_o` held, counter at 0.
  - When `en`=1: load active duty and dir from shadow, then go to RUN.
- **RUN**
  - Counter runs 0..period−1.
  - `pwm_o` is high while counter < active duty, so it is high for exactly duty cycles per period.
  - At counter = period−1, compare shadow sign with `dir_o`:
    - If they differ and shadow mag ≠ 0: go to DEAD.
    - Otherwise: load duty from shadow, counter wraps to 0, new period starts.
- **DEAD**
  - `pwm_o`=0, `brake_o`=1 for exactly `dead` cycles.
  - Then load `dir_o` and duty from shadow, counter to 0, go to RUN (new period starts).
- **`en` low** in any state: go to IDLE at the next edge. The shadow register is kept.
- **Outputs.** All outputs are registered, and `pwm_o` and `brake_o` are never high together.

## Timing

- **Reset values.**
  - `pwm_o`, `dir_o`, `brake_o`, `period_o` = 0.
  - State IDLE, shadow = 0 forward, active duty 0.
  - Reset asserted mid-period drops `pwm_o` asynchronously.
- **Period start.** `period_o` is high on the first cycle of every period, and that is also the first possible `pwm_o` high cycle.
  - First period starts 1 cycle after the edge at which `en` is first sampled high.
- **Strobe spacing.**
  - Steady state: `period_o` strobes exactly `period` cycles apart.
  - Across a reversal: `period` + `dead` cycles apart.
- **Command latency.**
  - A `cmd_valid_i` in cycles 0..period−2 of a period takes effect at the next period start.
  - A strobe in the last cycle (counter = period−1) takes effect one period later.
- **Reversal with `cmd_valid_i` during DEAD.** Updates the shadow. The value present at DEAD exit is loaded.
- **Boundary values.**
  - duty 0: `pwm_o` is never high.
  - duty = period: `pwm_o` is continuously high across periods with no gap cycle.

## Test plan

Common setup: period=100, duty_max=90, dead=4, nbits=16.

1. **Basic duty.** Reset, en=1, cmd +40 → each period: `pwm_o` 40 high then 60 low, `dir_o`=0, `period_o` every 100 cycles.
2. **Reversal.** From +40 steady, cmd −25 at counter 10 → period completes with 40 high. Then 4 cycles `brake_o`=1 / `pwm_o`=0. Then `dir_o`=1 and 25 high per period. Strobe spacing 104 once.
3. **Saturation.**
   - cmd +500 → 90 high, `dir_o`=0.
   - cmd −32768 → dead-time, then 90 high, `dir_o`=1.
4. **Zero and late strobe.**
   - From −25, cmd 0 → `dir_o` stays 1, no brake, `pwm_o` low all period.
   - cmd +30 strobed at counter 99 → applies one period later, after dead-time.
5. **Last strobe wins.** Two strobes +10 then +60 in one period → next period 60 high.
6. **Interrupts.**
   - Assert `rst` at counter 20 with duty 40 → `pwm_o`=0 immediately, all outputs 0.
   - Repeat with `en` dropped → IDLE, `pwm_o`=0 next cycle.
   - Re-enable → `period_o` strobe 1 cycle later.
